np_mem_arbiter: RTL and testbench

//   Shares one single-port synchronous word memory between three requesters:

---
 rtl/np_pkg.sv | 23 ++
 rtl/np_arb_pick.sv | 32 +++
 rtl/np_mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_np_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/np_pkg.sv
// np_pkg: shared defaults, FSM encodings and requester ids for np_mem_arbiter.
package np_pkg;

   localparam int unsigned NpWidth       = 32;
   localparam int unsigned NpAddrSize    = 12;
   localparam int unsigned NpStarveLimit = 4;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } np_state_e;

   // Requester ids; PortNone marks "no owner".
   typedef enum logic [1:0] {
      PortNone = 2'd0,
      PortH    = 2'd1,
      PortD    = 2'd2,
      PortI    = 2'd3
   } np_port_e;

endpackage

// File: rtl/np_arb_pick.sv
// np_arb_pick: combinational winner select. Host always wins; between data and fetch,
// data wins unless the fetch side has been promoted (starvation or round-robin turn).
module np_arb_pick
   import np_pkg::*;
(
   input  logic     h_req_i,
   input  logic     d_req_i,
   input  logic     i_req_i,
   input  logic     starve_i,
   input  logic     rr_i_first_i,
   output np_port_e winner_o
);

   logic i_first;

   assign i_first = starve_i | rr_i_first_i;

   // Priority select among the live requests.
   always_comb begin
      winner_o = PortNone;
      if (h_req_i) begin
         winner_o = PortH;
      end else if (d_req_i && i_req_i) begin
         winner_o = i_first ? PortI : PortD;
      end else if (d_req_i) begin
         winner_o = PortD;
      end else if (i_req_i) begin
         winner_o = PortI;
      end
   end

endmodule

// File: rtl/np_mem_arbiter.sv
// np_mem_arbiter: shares one single-port synchronous RAM between host (h), data (d) and
// instruction fetch (i). Every access runs arbitrate -> access -> (read) response.
// Build option: define NP_ARB_RR_EN for round-robin d/i arbitration instead of fixed
// priority with a fetch starvation counter.
module np_mem_arbiter
   import np_pkg::*;
#(
   parameter int unsigned WIDTH        = NpWidth,
   parameter int unsigned ADDRSIZE     = NpAddrSize,
   parameter int unsigned STARVE_LIMIT = NpStarveLimit
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                h_req,
   input  logic                h_wr,
   input  logic [ADDRSIZE-1:0] h_addr,
   input  logic [WIDTH-1:0]    h_wdata,
   output logic                h_gnt,
   output logic                h_rvalid,
   output logic [WIDTH-1:0]    h_rdata,
   input  logic                i_req,
   input  logic [ADDRSIZE-1:0] i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [WIDTH-1:0]    i_rdata,
   input  logic                d_req,
   input  logic                d_wr,
   input  logic [ADDRSIZE-1:0] d_addr,
   input  logic [WIDTH-1:0]    d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [WIDTH-1:0]    d_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDRSIZE-1:0] mem_addr,
   output logic [WIDTH-1:0]    mem_wdata,
   input  logic [WIDTH-1:0]    mem_rdata,
   output logic                busy
);

   np_state_e           state_q, state_d;
   np_port_e            owner_q, owner_d;
   np_port_e            winner;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic                starve;
   logic                rr_i_first;
   logic                pick_valid;

   // A grant is only taken while idle; the pick is ignored in other states.
   assign pick_valid = (state_q == StIdle) && (winner != PortNone);

   np_arb_pick u_pick (
      .h_req_i      (h_req),
      .d_req_i      (d_req),
      .i_req_i      (i_req),
      .starve_i     (starve),
      .rr_i_first_i (rr_i_first),
      .winner_o     (winner)
   );

`ifndef NP_ARB_RR_EN
   localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

   assign starve     = (starve_cnt_q >= CntW'(STARVE_LIMIT));
   assign rr_i_first = 1'b0;

   // Count fetch arbitrations lost in a row; saturates at the limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!i_req) begin
         starve_cnt_d = '0;
      end else if (pick_valid) begin
         if (winner == PortI) begin
            starve_cnt_d = '0;
         end else if (starve_cnt_q < CntW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   logic rr_i_first_q, rr_i_first_d;

   assign starve     = 1'b0;
   assign rr_i_first = rr_i_first_q;

   // Whichever of d/i was granted last drops to lowest priority; host grants leave it.
   always_comb begin
      rr_i_first_d = rr_i_first_q;
      if (pick_valid && (winner == PortD)) begin
         rr_i_first_d = 1'b1;
      end else if (pick_valid && (winner == PortI)) begin
         rr_i_first_d = 1'b0;
      end
   end

   // Round-robin pointer register; d goes first after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_i_first_q <= 1'b0;
      end else begin
         rr_i_first_q <= rr_i_first_d;
      end
   end
`endif

   // Sequencing FSM next state and registered memory command.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d  = StAccess;
               owner_d  = winner;
               mem_en_d = 1'b1;
               case (winner)
                  PortH: begin
                     mem_we_d   = h_wr;
                     mem_addr_d = h_addr;
                     if (h_wr) mem_wdata_d = h_wdata;
                  end
                  PortD: begin
                     mem_we_d   = d_wr;
                     mem_addr_d = d_addr;
                     if (d_wr) mem_wdata_d = d_wdata;
                  end
                  PortI: begin
                     mem_addr_d = i_addr;
                  end
                  default: ;
               endcase
            end
         end
         StAccess: begin
            // Writes finish here; reads need one more cycle for the RAM output.
            if (mem_we_q) begin
               state_d = StIdle;
               owner_d = PortNone;
            end else begin
               state_d = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
            owner_d = PortNone;
         end
         default: begin
            state_d = StIdle;
            owner_d = PortNone;
         end
      endcase
   end

   // State and memory command registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         owner_q     <= PortNone;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != StIdle);

   assign h_gnt    = (state_q == StAccess) && (owner_q == PortH);
   assign d_gnt    = (state_q == StAccess) && (owner_q == PortD);
   assign i_gnt    = (state_q == StAccess) && (owner_q == PortI);
   assign h_rvalid = (state_q == StResp) && (owner_q == PortH);
   assign d_rvalid = (state_q == StResp) && (owner_q == PortD);
   assign i_rvalid = (state_q == StResp) && (owner_q == PortI);
   assign h_rdata  = h_rvalid ? mem_rdata : '0;
   assign d_rdata  = d_rvalid ? mem_rdata : '0;
   assign i_rdata  = i_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_np_mem_arbiter.sv
// tb_np_mem_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model (arbitration rules, latencies, reference memory contents).
module tb_np_mem_arbiter;

   localparam int unsigned W   = 32;
   localparam int unsigned A   = 12;
   localparam int unsigned LIM = 4;
   localparam int unsigned NW  = 1 << A;

   logic         clk = 1'b0;
   logic         reset;
   logic         h_req, h_wr, d_req, d_wr, i_req;
   logic [A-1:0] h_addr, d_addr, i_addr;
   logic [W-1:0] h_wdata, d_wdata;
   logic         h_gnt, h_rvalid, d_gnt, d_rvalid, i_gnt, i_rvalid;
   logic [W-1:0] h_rdata, d_rdata, i_rdata;
   logic         mem_en, mem_we;
   logic [A-1:0] mem_addr;
   logic [W-1:0] mem_wdata, mem_rdata;
   logic         busy;

   always #5 clk = ~clk;

   np_mem_arbiter #(.WIDTH(W), .ADDRSIZE(A), .STARVE_LIMIT(LIM)) dut (
      .clk       (clk),
      .reset     (reset),
      .h_req     (h_req),
      .h_wr      (h_wr),
      .h_addr    (h_addr),
      .h_wdata   (h_wdata),
      .h_gnt     (h_gnt),
      .h_rvalid  (h_rvalid),
      .h_rdata   (h_rdata),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt),
      .i_rvalid  (i_rvalid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Environment RAM: synchronous single port, read data valid the cycle after mem_en.
   logic [W-1:0] ram [NW];
   logic         ram_clr;
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int k = 0; k < NW; k++) ram[k] <= '0;
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata    <= ram[mem_addr];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h (cycle time %0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction-level reference state. Port vectors are {h, d, i}.
   logic [W-1:0] ref_mem [NW];
   int           cyc = 0, free_at = 0, samp_cyc = 0, gnt_cyc = -10, rv_cyc = -10;
   logic [2:0]   gnt_vec, rv_vec, gnt_seen;
   logic         exp_we;
   logic [A-1:0] exp_addr;
   logic [W-1:0] exp_wdata, rv_data;
   int           starve = 0;
   bit           rr_i = 1'b0;
   bit           chk_en = 1'b0;

   // Apply the arbitration rules to the inputs of the current cycle.
   task automatic model_arb();
      logic [2:0]   win;
      logic         wr;
      logic [A-1:0] a;
      logic [W-1:0] wd;
      bit           i_pri;
      if (reset) begin
         gnt_cyc = -10; rv_cyc = -10; samp_cyc = cyc; free_at = cyc + 1;
         starve = 0; rr_i = 1'b0;
         return;
      end
`ifdef NP_ARB_RR_EN
      i_pri = rr_i;
`else
      i_pri = (starve >= LIM);
`endif
      win = 3'b000;
      if (cyc >= free_at) begin
         if (h_req)               win = 3'b100;
         else if (d_req && i_req) win = i_pri ? 3'b001 : 3'b010;
         else if (d_req)          win = 3'b010;
         else if (i_req)          win = 3'b001;
      end
`ifdef NP_ARB_RR_EN
      if (win == 3'b010) rr_i = 1'b1;
      else if (win == 3'b001) rr_i = 1'b0;
`else
      if (!i_req || win == 3'b001) starve = 0;
      else if (win != 3'b000 && starve < LIM) starve++;
`endif
      if (win == 3'b000) return;
      case (win)
         3'b100:  begin wr = h_wr; a = h_addr; wd = h_wdata; end
         3'b010:  begin wr = d_wr; a = d_addr; wd = d_wdata; end
         default: begin wr = 1'b0; a = i_addr; wd = '0; end
      endcase
      samp_cyc = cyc; gnt_cyc = cyc + 1; gnt_vec = win;
      exp_we = wr; exp_addr = a; exp_wdata = wd;
      if (wr) begin
         ref_mem[a] = wd;
         free_at = cyc + 2;
      end else begin
         rv_cyc = cyc + 2; rv_vec = win; rv_data = ref_mem[a];
         free_at = cyc + 3;
      end
   endtask

   task automatic check_outputs();
      logic [2:0] g_exp, r_exp;
      g_exp = (gnt_cyc == cyc) ? gnt_vec : 3'b000;
      r_exp = (rv_cyc == cyc) ? rv_vec : 3'b000;
      check_eq("gnt", {h_gnt, d_gnt, i_gnt}, g_exp);
      check_eq("mem_en", mem_en, gnt_cyc == cyc);
      check_eq("mem_we", mem_we, (gnt_cyc == cyc) && exp_we);
      if (gnt_cyc == cyc) begin
         check_eq("mem_addr", mem_addr, exp_addr);
         if (exp_we) check_eq("mem_wdata", mem_wdata, exp_wdata);
      end
      check_eq("rvalid", {h_rvalid, d_rvalid, i_rvalid}, r_exp);
      check_eq("h_rdata", h_rdata, r_exp[2] ? rv_data : '0);
      check_eq("d_rdata", d_rdata, r_exp[1] ? rv_data : '0);
      check_eq("i_rdata", i_rdata, r_exp[0] ? rv_data : '0);
      check_eq("busy", busy, (cyc > samp_cyc) && (cyc < free_at));
      gnt_seen = {h_gnt, d_gnt, i_gnt};
   endtask

   task automatic tick();
      model_arb();
      @(negedge clk);
      cyc++;
      if (chk_en) check_outputs();
   endtask

   task automatic clear_reqs();
      h_req = 1'b0; d_req = 1'b0; i_req = 1'b0;
   endtask

   task automatic apply_reset(input int n);
      clear_reqs();
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   // Bounded wait for any grant in 'which'; returns the cycle it appeared.
   task automatic wait_gnt(input string tag, input logic [2:0] which, output int at);
      at = -1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if ((gnt_seen & which) != 3'b000) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check_eq({tag, "_timeout"}, 0, 1);
   endtask

   function automatic logic [A-1:0] rnd_addr();
      if ($urandom_range(0, 7) == 0) return {A{1'b1}};
      return A'($urandom_range(0, 15));
   endfunction

   initial begin
      int         req_c, at, n;
      logic [2:0] order [$];
      logic [2:0] exp_g;

      reset = 1'b1; ram_clr = 1'b1; clear_reqs();
      h_wr = 1'b0; d_wr = 1'b0; h_addr = '0; d_addr = '0; i_addr = '0;
      h_wdata = '0; d_wdata = '0; gnt_seen = '0;
      for (int k = 0; k < NW; k++) ref_mem[k] = '0;
      tick(); tick();
      ram_clr = 1'b0; chk_en = 1'b1;
      tick();
      reset = 1'b0;

      // 1: idle after reset
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_busy", busy, 0);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (mem_en) n++;
      end
      check_eq("idle_mem_en_count", n, 0);

      // 2: host write then read back
      h_req = 1'b1; h_wr = 1'b1; h_addr = 12'h010; h_wdata = 32'hDEADBEEF;
      req_c = cyc;
      wait_gnt("h_wr_gnt", 3'b100, at);
      check_eq("h_wr_gnt_lat", at - req_c, 1);
      h_req = 1'b0;
      tick();
      h_req = 1'b1; h_wr = 1'b0;
      req_c = cyc;
      wait_gnt("h_rd_gnt", 3'b100, at);
      check_eq("h_rd_gnt_lat", at - req_c, 1);
      h_req = 1'b0;
      tick();
      check_eq("h_rd_rvalid", h_rvalid, 1);
      check_eq("h_rd_data", h_rdata, 32'hDEADBEEF);
      repeat (2) tick();

      // 3: all three requesters at once
      h_req = 1'b1; h_wr = 1'b0; h_addr = 12'h010;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 12'h020;
      i_req = 1'b1; i_addr = 12'h000;
      for (int k = 0; k < 40 && order.size() < 3; k++) begin
         tick();
         if (gnt_seen != 3'b000) order.push_back(gnt_seen);
         if (gnt_seen[2]) h_req = 1'b0;
         if (gnt_seen[1]) d_req = 1'b0;
         if (gnt_seen[0]) i_req = 1'b0;
      end
      check_eq("t3_count", order.size(), 3);
      if (order.size() == 3) begin
         check_eq("t3_first", order[0], 3'b100);
         check_eq("t3_second", order[1], 3'b010);
         check_eq("t3_third", order[2], 3'b001);
      end
      clear_reqs();
      n = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (gnt_seen != 3'b000) n++;
      end
      check_eq("t3_extra_gnt", n, 0);

      // 4: d and i held continuously; first ten d/i grants
      apply_reset(1);
      tick();
      d_req = 1'b1; d_wr = 1'b0; d_addr = 12'h005;
      i_req = 1'b1; i_addr = 12'h004;
      order.delete();
      for (int k = 0; k < 120 && order.size() < 10; k++) begin
         tick();
         if (gnt_seen != 3'b000) order.push_back(gnt_seen);
         if (gnt_seen[1]) d_addr = rnd_addr();
      end
      check_eq("t4_count", order.size(), 10);
      for (int k = 0; k < order.size(); k++) begin
`ifdef NP_ARB_RR_EN
         exp_g = (k % 2 == 1) ? 3'b001 : 3'b010;
`else
         exp_g = (k % 5 == 4) ? 3'b001 : 3'b010;
`endif
         check_eq($sformatf("t4_grant%0d", k), order[k], exp_g);
      end
      clear_reqs();
      repeat (3) tick();

      // 5: reset during the response cycle of a fetch
      i_req = 1'b1; i_addr = 12'h000;
      wait_gnt("t5_gnt", 3'b001, at);
      i_req = 1'b0;
      tick();
      check_eq("t5_resp_rvalid", i_rvalid, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("t5_rst_rvalid", i_rvalid, 0);
      check_eq("t5_rst_busy", busy, 0);
      tick();

      // 6: store at the top address, fetch it back
      d_req = 1'b1; d_wr = 1'b1; d_addr = 12'hFFF; d_wdata = 32'h1;
      wait_gnt("t6_store", 3'b010, at);
      d_req = 1'b0;
      tick();
      i_req = 1'b1; i_addr = 12'hFFF;
      wait_gnt("t6_fetch", 3'b001, at);
      i_req = 1'b0;
      tick();
      check_eq("t6_rvalid", i_rvalid, 1);
      check_eq("t6_rdata", i_rdata, 32'h1);
      tick();

      // Random traffic with occasional resets.
      for (int k = 0; k < 2000; k++) begin
         if (gnt_seen[2]) h_req = 1'b0;
         if (gnt_seen[1]) d_req = 1'b0;
         if (gnt_seen[0]) i_req = 1'b0;
         if (!h_req && $urandom_range(0, 5) == 0) begin
            h_req = 1'b1; h_wr = 1'($urandom_range(0, 1));
            h_addr = rnd_addr(); h_wdata = $urandom;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
            d_addr = rnd_addr(); d_wdata = $urandom;
         end
         if (!i_req && $urandom_range(0, 1) == 0) begin
            i_req = 1'b1; i_addr = rnd_addr();
         end
         reset = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0;
      clear_reqs();
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
